mcb_ini_tmr: RTL and testbench
==============================

# mcb_ini_tmr

Timing/counter companion to the SDRAM back-end initialisation FSM. It sits directly upstream of that FSM and supplies its three inputs: the power-up wait-done flag, the "N auto-refreshes issued" flag and the free-running command-interval counter. After initialisation completes (`i_ready` high), it also generates the periodic auto-refresh request, with a pending-count and req/ack handshake, for the main command scheduler.

## Interface
Parameters:
- `I_WAIT_CYC`, default 20000: power-up wait in `mcb_clk` cycles (200 us at 100 MHz). Must be ≥1.
- `WAIT_CNT_W`, default 15: wait counter width. Must satisfy `I_WAIT_CYC-1 < 2^WAIT_CNT_W`.
- `I_REF_NUM`, default 8: number of auto-refreshes required during init. Must be ≥1.
- `REF_NUM_W`, default 4: refresh counter width. Must hold `I_REF_NUM`.
- `I_CMD_CNT_W`, default 4: command-interval counter width. Shared with the init FSM.
- `REF_INT_CYC`, default 780: periodic refresh interval in cycles (7.8 us). Must be ≥2.
- `REF_INT_W`, default 10: interval timer width.
- `REF_PEND_MAX`, default 3: saturation value of the pending-refresh count. Must be ≥1.

Ports:
- `mcb_clk`  in  1  clock; all logic on the rising edge.
- `mcb_rst_n`  in  1  asynchronous, active-low reset.
- `mcb_sclr_n`  in  1  synchronous clear, active low.
- `i_cmd_cnt_sclr`  in  1  clear request for the command counter, from the init FSM.
- `i_ref`  in  1  one-cycle init auto-refresh strobe, from the init FSM.
- `i_ready`  in  1  init complete, from the init FSM.
- `r_ack`  in  1  periodic refresh accepted by the scheduler.
- `i_ini_w_done`  out  1  power-up wait elapsed (sticky).
- `i_ref_n_done`  out  1  `I_REF_NUM` init refreshes issued or being issued.
- `i_cmd_cnt`  out  `I_CMD_CNT_W`  command-interval counter.
- `r_req`  out  1  one or more periodic refreshes pending.
- `r_urgent`  out  1  pending count at `REF_PEND_MAX`.

## Operation
- **Reset** (`mcb_rst_n`=0, asynchronous) and **sync clear** (`mcb_sclr_n`=0, on the next edge) both do the following:
  - all counters go to 0;
  - `i_ini_w_done`=0, `i_cmd_cnt`=0, `r_req`=0, `r_urgent`=0;
  - `i_ref_n_done` is combinational and reads 0 unless `I_REF_NUM`=1 and `i_ref`=1.
- Sync clear takes priority over every other update.
- **Wait counter `w_cnt`:**
  - Increments each cycle while `i_ini_w_done`=0.
  - On the edge where `w_cnt == I_WAIT_CYC-1`, the registered `i_ini_w_done` is set and the counter freezes.
  - The flag stays set until reset or sync clear.
- **Init refresh counter `ref_cnt`:**
  - Increments on each cycle with `i_ref`=1 and `i_ready`=0.
  - Saturates at `I_REF_NUM`.
  - `i_ref_n_done = (ref_cnt + i_ref) >= I_REF_NUM`, combinational. It is therefore valid both during the Nth `i_ref` pulse (zero-tRFC configuration) and during the following tRFC wait.
- **Command counter `i_cmd_cnt`** (registered):
  - `i_cmd_cnt_sclr`=1 → 0 on the next edge.
  - Otherwise it increments and saturates at all-ones. It never wraps, so an interval compare cannot re-fire.
- **Periodic refresh** (only while `i_ready`=1):
  - Timer `r_tmr` counts 0..`REF_INT_CYC-1` and wraps.
  - The wrap cycle produces `tick`.
  - `pend_next = sat(pend + tick - (r_ack & pend!=0))`, clamped to 0..`REF_PEND_MAX`.
  - `tick` and `r_ack` in the same cycle leave `pend` unchanged, including at `REF_PEND_MAX`.
  - `r_ack` with `pend`=0 is ignored.
- **Periodic refresh while `i_ready`=0:** `r_tmr` and `pend` are held at 0.
- **Output decode:** `r_req = (pend != 0)` and `r_urgent = (pend == REF_PEND_MAX)`, both decoded from registers.

## Timing
- `i_ini_w_done` rises after the `I_WAIT_CYC`-th rising edge following reset release or sync clear.
- `i_cmd_cnt` reads 0 in the cycle after `i_cmd_cnt_sclr`, then 1, 2, … one per cycle. The init FSM's compare `cnt == CtXm1-1` therefore holds the wait state for exactly `CtXm1` cycles.
- `i_ref_n_done` has zero latency from `i_ref`. It reflects the registered `ref_cnt` one edge after each `i_ref`.
- **First refresh tick:** if `i_ready` rises at edge E, `r_tmr` is 0 in the cycle after E and `tick` occurs `REF_INT_CYC` cycles after E. `r_req` rises one edge after `tick`.
- **Handshake:**
  - `r_req` stays high until acknowledged.
  - The scheduler pulses `r_ack` for one cycle per refresh issued.
  - `r_req` falls one edge after the `r_ack` that empties `pend`.
- **Reset mid-operation:** an asynchronous reset at any point returns all outputs to their reset values immediately. The power-up wait restarts in full.

## Test plan
Test configuration for all scenarios: `I_WAIT_CYC`=10, `I_REF_NUM`=2, `REF_INT_CYC`=8, `REF_PEND_MAX`=3, `I_CMD_CNT_W`=4.
1. **Power-up wait:** release reset → `i_ini_w_done` 0 through edge 9, 1 after edge 10 and stays 1 for 50 more cycles. Pull `mcb_sclr_n` low for 1 cycle → `i_ini_w_done` drops to 0 and next rises 10 edges after the clear.
2. **Command counter:** pulse `i_cmd_cnt_sclr` → next cycles read 0,1,2,…,15. Hold 20 cycles → stays 15 (no wrap). Pulse sclr while at 7 → 0 on the next cycle.
3. **Init refresh:** `i_ref` pulse #1 → `i_ref_n_done` 0 during the pulse, 0 afterwards. Pulse #2 → `i_ref_n_done` 1 during the pulse and stays 1. Pulse #3 → `ref_cnt` stays 2.
4. **Periodic refresh:** assert `i_ready` at edge E with no `r_ack` → `r_req` rises at E+9, `r_urgent` rises at E+25.
5. **Handshake and saturation:**
   - At `pend`=3, `r_ack` coincident with `tick` → `pend` stays 3.
   - Then 3 acks → `r_req` 0.
   - An extra ack at 0 → still 0.
   - Drop `i_ready` with `pend`=2 → `r_req` 0 on the next edge.
6. **Async reset mid-count:** assert `mcb_rst_n`=0 mid-cycle with `pend`=2 and `i_cmd_cnt`=5 → all outputs 0 immediately without a clock edge.

Source files
------------

// File: rtl/mcb_ini_tmr.sv
`default_nettype none
// ============================================================================
//  Module   : mcb_ini_tmr
//  Purpose  : Timing/counter companion to the SDRAM back-end init FSM.
//             Supplies the power-up wait-done flag, the "N init refreshes
//             issued" flag and a saturating command-interval counter. Once
//             init is complete it also raises periodic auto-refresh requests
//             (pending count with req/ack handshake) for the scheduler.
//  Ports    :
//    mcb_clk         in   clock, rising edge
//    mcb_rst_n       in   asynchronous active-low reset
//    mcb_sclr_n      in   synchronous clear, active low (highest priority)
//    i_cmd_cnt_sclr  in   clear the command counter on the next edge
//    i_ref           in   one-cycle init auto-refresh strobe
//    i_ready         in   init complete
//    r_ack           in   periodic refresh accepted by the scheduler
//    i_ini_w_done    out  power-up wait elapsed (sticky)
//    i_ref_n_done    out  I_REF_NUM init refreshes issued or being issued
//    i_cmd_cnt       out  command-interval counter (saturating)
//    r_req           out  one or more periodic refreshes pending
//    r_urgent        out  pending count at REF_PEND_MAX
//  Revision : 1.0  initial release
// ============================================================================
module mcb_ini_tmr #(
  parameter int I_WAIT_CYC   = 20000,
  parameter int WAIT_CNT_W   = 15,
  parameter int I_REF_NUM    = 8,
  parameter int REF_NUM_W    = 4,
  parameter int I_CMD_CNT_W  = 4,
  parameter int REF_INT_CYC  = 780,
  parameter int REF_INT_W    = 10,
  parameter int REF_PEND_MAX = 3
) (
  input  logic                   mcb_clk,
  input  logic                   mcb_rst_n,
  input  logic                   mcb_sclr_n,
  input  logic                   i_cmd_cnt_sclr,
  input  logic                   i_ref,
  input  logic                   i_ready,
  input  logic                   r_ack,
  output logic                   i_ini_w_done,
  output logic                   i_ref_n_done,
  output logic [I_CMD_CNT_W-1:0] i_cmd_cnt,
  output logic                   r_req,
  output logic                   r_urgent
);

  localparam int PEND_W = (REF_PEND_MAX < 2) ? 1 : $clog2(REF_PEND_MAX + 1);

  localparam logic [WAIT_CNT_W-1:0]  c_WAIT_LAST = WAIT_CNT_W'(I_WAIT_CYC - 1);
  localparam logic [REF_NUM_W-1:0]   c_REF_NUM   = REF_NUM_W'(I_REF_NUM);
  localparam logic [REF_NUM_W:0]     c_REF_NUM_X = (REF_NUM_W + 1)'(I_REF_NUM);
  localparam logic [REF_INT_W-1:0]   c_TMR_LAST  = REF_INT_W'(REF_INT_CYC - 1);
  localparam logic [PEND_W-1:0]      c_PEND_MAX  = PEND_W'(REF_PEND_MAX);
  localparam logic [I_CMD_CNT_W-1:0] c_CMD_MAX   = '1;

  logic [WAIT_CNT_W-1:0]  r_w_cnt;
  logic                   r_w_done;
  logic [REF_NUM_W-1:0]   r_ref_cnt;
  logic [I_CMD_CNT_W-1:0] r_cmd_cnt;
  logic [REF_INT_W-1:0]   r_tmr;
  logic                   r_tick;
  logic [PEND_W-1:0]      r_pend;

  logic [REF_NUM_W:0]     w_ref_sum;
  logic                   w_ack_eff;

  // ---------------------------------------------------------------------------
  // Power-up wait: counter freezes once the sticky done flag is set.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_w_cnt  <= '0;
      r_w_done <= 1'b0;
    end else if (!mcb_sclr_n) begin
      r_w_cnt  <= '0;
      r_w_done <= 1'b0;
    end else if (!r_w_done) begin
      if (r_w_cnt == c_WAIT_LAST) begin
        r_w_done <= 1'b1;
      end else begin
        r_w_cnt <= r_w_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Init refresh count, saturating at I_REF_NUM. The done flag adds the live
  // strobe so the Nth pulse itself already reports done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_ref_cnt <= '0;
    end else if (!mcb_sclr_n) begin
      r_ref_cnt <= '0;
    end else if (i_ref && !i_ready && (r_ref_cnt != c_REF_NUM)) begin
      r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign w_ref_sum    = {1'b0, r_ref_cnt} + {{REF_NUM_W{1'b0}}, i_ref};
  assign i_ref_n_done = (w_ref_sum >= c_REF_NUM_X);

  // ---------------------------------------------------------------------------
  // Command-interval counter: saturates at all-ones so an interval compare in
  // the init FSM can never fire a second time after a wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_cmd_cnt <= '0;
    end else if (!mcb_sclr_n || i_cmd_cnt_sclr) begin
      r_cmd_cnt <= '0;
    end else if (r_cmd_cnt != c_CMD_MAX) begin
      r_cmd_cnt <= r_cmd_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Periodic refresh. The wrap of r_tmr is registered into r_tick, so the
  // pending count (and hence r_req) moves one edge after the tick cycle.
  // ---------------------------------------------------------------------------
  assign w_ack_eff = r_ack && (r_pend != '0);

  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      r_tmr  <= '0;
      r_tick <= 1'b0;
      r_pend <= '0;
    end else if (!mcb_sclr_n || !i_ready) begin
      r_tmr  <= '0;
      r_tick <= 1'b0;
      r_pend <= '0;
    end else begin
      r_tick <= (r_tmr == c_TMR_LAST);
      if (r_tmr == c_TMR_LAST) begin
        r_tmr <= '0;
      end else begin
        r_tmr <= r_tmr + 1'b1;
      end
      // Tick and effective ack together cancel, including at saturation.
      if (r_tick && !w_ack_eff) begin
        if (r_pend != c_PEND_MAX) begin
          r_pend <= r_pend + 1'b1;
        end
      end else if (!r_tick && w_ack_eff) begin
        r_pend <= r_pend - 1'b1;
      end
    end
  end

  assign i_ini_w_done = r_w_done;
  assign i_cmd_cnt    = r_cmd_cnt;
  assign r_req        = (r_pend != '0);
  assign r_urgent     = (r_pend == c_PEND_MAX);

endmodule
`default_nettype wire

// File: tb/tb_mcb_ini_tmr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mcb_ini_tmr
//  Purpose  : Directed self-checking bench for mcb_ini_tmr with
//             I_WAIT_CYC=10, I_REF_NUM=2, REF_INT_CYC=8, REF_PEND_MAX=3,
//             I_CMD_CNT_W=4. Inputs change and outputs are sampled 1 ns
//             after each rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mcb_ini_tmr;

  logic       mcb_clk;
  logic       mcb_rst_n;
  logic       mcb_sclr_n;
  logic       i_cmd_cnt_sclr;
  logic       i_ref;
  logic       i_ready;
  logic       r_ack;
  logic       i_ini_w_done;
  logic       i_ref_n_done;
  logic [3:0] i_cmd_cnt;
  logic       r_req;
  logic       r_urgent;

  int n_checks;
  int n_errors;

  mcb_ini_tmr #(
    .I_WAIT_CYC   (10),
    .WAIT_CNT_W   (4),
    .I_REF_NUM    (2),
    .REF_NUM_W    (2),
    .I_CMD_CNT_W  (4),
    .REF_INT_CYC  (8),
    .REF_INT_W    (3),
    .REF_PEND_MAX (3)
  ) dut (
    .mcb_clk        (mcb_clk),
    .mcb_rst_n      (mcb_rst_n),
    .mcb_sclr_n     (mcb_sclr_n),
    .i_cmd_cnt_sclr (i_cmd_cnt_sclr),
    .i_ref          (i_ref),
    .i_ready        (i_ready),
    .r_ack          (r_ack),
    .i_ini_w_done   (i_ini_w_done),
    .i_ref_n_done   (i_ref_n_done),
    .i_cmd_cnt      (i_cmd_cnt),
    .r_req          (r_req),
    .r_urgent       (r_urgent)
  );

  initial mcb_clk = 1'b0;
  always #5 mcb_clk = ~mcb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge mcb_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wdone"},  {31'd0, i_ini_w_done}, 32'd0);
    chk({tag, "_refdn"},  {31'd0, i_ref_n_done}, 32'd0);
    chk({tag, "_cmd"},    {28'd0, i_cmd_cnt},    32'd0);
    chk({tag, "_req"},    {31'd0, r_req},        32'd0);
    chk({tag, "_urgent"}, {31'd0, r_urgent},     32'd0);
  endtask

  initial begin
    logic hold_ok;
    n_checks       = 0;
    n_errors       = 0;
    mcb_rst_n      = 1'b0;
    mcb_sclr_n     = 1'b1;
    i_cmd_cnt_sclr = 1'b0;
    i_ref          = 1'b0;
    i_ready        = 1'b0;
    r_ack          = 1'b0;

    // ---- reset state ----
    #12;
    chk_all_zero("rst");

    // ---- 1. power-up wait ----
    @(posedge mcb_clk); #1;
    mcb_rst_n = 1'b1;
    step(9);
    chk("wdone_e9", {31'd0, i_ini_w_done}, 32'd0);
    step(1);
    chk("wdone_e10", {31'd0, i_ini_w_done}, 32'd1);
    hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      hold_ok = hold_ok & i_ini_w_done;
    end
    chk("wdone_hold50", {31'd0, hold_ok}, 32'd1);
    mcb_sclr_n = 1'b0;
    step(1);
    mcb_sclr_n = 1'b1;
    chk("sclr_wdone", {31'd0, i_ini_w_done}, 32'd0);
    chk("sclr_cmd",   {28'd0, i_cmd_cnt},    32'd0);
    step(9);
    chk("sclr_wdone_e9", {31'd0, i_ini_w_done}, 32'd0);
    step(1);
    chk("sclr_wdone_e10", {31'd0, i_ini_w_done}, 32'd1);

    // ---- 2. command counter ----
    i_cmd_cnt_sclr = 1'b1;
    step(1);
    i_cmd_cnt_sclr = 1'b0;
    chk("cmd_0", {28'd0, i_cmd_cnt}, 32'd0);
    for (int k = 1; k <= 15; k++) begin
      step(1);
      chk("cmd_seq", {28'd0, i_cmd_cnt}, k);
    end
    step(20);
    chk("cmd_sat", {28'd0, i_cmd_cnt}, 32'd15);
    i_cmd_cnt_sclr = 1'b1;
    step(1);
    i_cmd_cnt_sclr = 1'b0;
    step(7);
    chk("cmd_at7", {28'd0, i_cmd_cnt}, 32'd7);
    i_cmd_cnt_sclr = 1'b1;
    step(1);
    i_cmd_cnt_sclr = 1'b0;
    chk("cmd_clr7", {28'd0, i_cmd_cnt}, 32'd0);

    // ---- 3. init refresh ----
    chk("ref_idle", {31'd0, i_ref_n_done}, 32'd0);
    i_ref = 1'b1; #1;
    chk("ref1_during", {31'd0, i_ref_n_done}, 32'd0);
    step(1); i_ref = 1'b0; #1;
    chk("ref1_after", {31'd0, i_ref_n_done}, 32'd0);
    step(2);
    i_ref = 1'b1; #1;
    chk("ref2_during", {31'd0, i_ref_n_done}, 32'd1);
    step(1); i_ref = 1'b0; #1;
    chk("ref2_after", {31'd0, i_ref_n_done}, 32'd1);
    step(2);
    i_ref = 1'b1;
    step(1); i_ref = 1'b0; #1;
    chk("ref3_cnt",   {30'd0, dut.r_ref_cnt}, 32'd2);
    chk("ref3_after", {31'd0, i_ref_n_done},  32'd1);

    // ---- 4. periodic refresh: ready rises at edge E ----
    i_ready = 1'b1;
    step(8);
    chk("req_e8", {31'd0, r_req}, 32'd0);
    step(1);
    chk("req_e9", {31'd0, r_req}, 32'd1);
    step(15);
    chk("urg_e24", {31'd0, r_urgent}, 32'd0);
    step(1);
    chk("urg_e25", {31'd0, r_urgent}, 32'd1);

    // ---- 5. handshake and saturation ----
    step(7);                       // now past E+32, tick cycle
    r_ack = 1'b1;
    step(1);                       // E+33: tick and ack together
    r_ack = 1'b0;
    chk("tickack_pend", {30'd0, dut.r_pend}, 32'd3);
    chk("tickack_urg",  {31'd0, r_urgent},   32'd1);
    r_ack = 1'b1;
    step(1);                       // E+34
    chk("ack1_urg", {31'd0, r_urgent}, 32'd0);
    chk("ack1_req", {31'd0, r_req},    32'd1);
    step(2);                       // E+36
    chk("ack3_req", {31'd0, r_req}, 32'd0);
    step(1);                       // E+37: ack at 0
    r_ack = 1'b0;
    chk("ack_extra_req", {31'd0, r_req},      32'd0);
    chk("ack_extra_pnd", {30'd0, dut.r_pend}, 32'd0);
    step(4);                       // E+41
    chk("req_again", {31'd0, r_req}, 32'd1);
    step(8);                       // E+49: pend 2
    chk("pend2", {30'd0, dut.r_pend}, 32'd2);
    i_ready = 1'b0;
    step(1);
    chk("drop_ready_req", {31'd0, r_req}, 32'd0);

    // ---- 6. async reset mid-count: ready rises at edge F ----
    i_ready = 1'b1;
    step(11);                      // F+11
    i_cmd_cnt_sclr = 1'b1;
    step(1);                       // F+12: cmd reads 0
    i_cmd_cnt_sclr = 1'b0;
    step(5);                       // F+17
    chk("pre_rst_cmd",  {28'd0, i_cmd_cnt},    32'd5);
    chk("pre_rst_req",  {31'd0, r_req},        32'd1);
    chk("pre_rst_wdn",  {31'd0, i_ini_w_done}, 32'd1);
    #3;
    mcb_rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    @(posedge mcb_clk); #1;
    i_ready   = 1'b0;
    mcb_rst_n = 1'b1;
    step(9);
    chk("arst_wdone_e9", {31'd0, i_ini_w_done}, 32'd0);
    step(1);
    chk("arst_wdone_e10", {31'd0, i_ini_w_done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
